direct_mapped_cache: RTL and testbench

DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

---
 rtl/direct_mapped_cache_pkg.sv | 23 ++
 rtl/main_mem.sv | 37 +++
 rtl/direct_mapped_cache.sv | 159 +++++++++++++++
 tb/tb_direct_mapped_cache.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/direct_mapped_cache_pkg.sv
// Shared widths, address-field sizes, FSM encoding and memory latency for the
// direct-mapped cache and its backing memory model.
package direct_mapped_cache_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned CACHE_BYTES = 16;
  localparam int unsigned LINE_W      = 32;
  localparam int unsigned SETS        = 4;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned INDEX_BITS  = 2;
  localparam int unsigned TAG_BITS    = 12;
  localparam int unsigned MEM_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/main_mem.sv
// Byte-wide backing memory: a write when data_vld is driven high with addr_en,
// otherwise a read whose byte returns MEM_LATENCY cycles later for one cycle.
module main_mem
  import direct_mapped_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  addr_en,
  inout  wire  [DATA_WIDTH-1:0] data,
  inout  wire                   data_vld
);

  // Cells hold data XOR addr[7:0], so an untouched (zero) cell reads as addr[7:0].
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr_pipe [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] vld_pipe;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic                  wr_c;

  assign wr_c      = addr_en && (data_vld == 1'b1);
  assign rd_addr_c = addr_pipe[MEM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (wr_c) mem[addr] <= data ^ DATA_WIDTH'(addr);
    vld_pipe     <= {vld_pipe[MEM_LATENCY-2:0], addr_en && !wr_c};
    addr_pipe[0] <= addr;
    for (int i = 1; i < MEM_LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  assign data_vld = vld_pipe[MEM_LATENCY-1] ? 1'b1 : 1'bz;
  assign data     = vld_pipe[MEM_LATENCY-1] ? (mem[rd_addr_c] ^ DATA_WIDTH'(rd_addr_c))
                                            : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/direct_mapped_cache.sv
// Write-back, write-allocate direct-mapped byte cache with a byte-serial
// tri-state link to main memory.
module direct_mapped_cache
  import direct_mapped_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = ADDR_W,
  parameter int unsigned DATA_WIDTH       = DATA_W,
  parameter int unsigned CACHE_SIZE       = CACHE_BYTES,
  parameter int unsigned CACHE_WORD_WIDTH = LINE_W,
  parameter int unsigned NUM_SETS         = SETS
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  addr_en,
  input  logic                  is_rd,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  data_vld,
  output logic                  is_hit,
  output logic                  cache_busy,
  output logic [ADDR_WIDTH-1:0] addr_main,
  output logic                  addr_main_en,
  inout  wire  [DATA_WIDTH-1:0] data_main,
  inout  wire                   data_main_vld
);

  localparam int unsigned LINE_BYTES = CACHE_WORD_WIDTH / DATA_WIDTH;
  localparam logic [OFFSET_BITS-1:0] LAST_OFF = OFFSET_BITS'(LINE_BYTES - 1);

  if (CACHE_SIZE != NUM_SETS * LINE_BYTES) begin : g_size_chk
    $error("CACHE_SIZE must equal NUM_SETS * line bytes");
  end

  logic [DATA_WIDTH-1:0]  line_data [NUM_SETS][LINE_BYTES];
  logic [TAG_BITS-1:0]    tag_arr   [NUM_SETS];
  logic [NUM_SETS-1:0]    valid_q, dirty_q;
  state_e                 state;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_rd;
  logic [DATA_WIDTH-1:0]  req_wdata, rd_data, wb_byte;
  logic [OFFSET_BITS-1:0] cnt;
  logic                   rd_drive, wb_drive;

  logic [INDEX_BITS-1:0]  in_idx_c, req_idx_c;
  logic [TAG_BITS-1:0]    in_tag_c, req_tag_c;
  logic [OFFSET_BITS-1:0] req_off_c, cnt_nxt_c;
  logic                   accept_c, hit_c;
  logic [DATA_WIDTH-1:0]  fill_byte_c;

  assign in_idx_c    = addr[OFFSET_BITS +: INDEX_BITS];
  assign in_tag_c    = addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
  assign req_off_c   = req_addr[0 +: OFFSET_BITS];
  assign req_idx_c   = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag_c   = req_addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
  assign cnt_nxt_c   = cnt + OFFSET_BITS'(1);
  assign accept_c    = (state == ST_IDLE) && !cache_busy && addr_en && (is_rd || data_vld);
  assign hit_c       = valid_q[in_idx_c] && (tag_arr[in_idx_c] == in_tag_c);
  // Write-allocate: the CPU byte replaces the memory byte as the line streams in.
  assign fill_byte_c = (!req_rd && cnt == req_off_c) ? req_wdata : data_main;

  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_BITS-1:0] t,
                                                      input logic [INDEX_BITS-1:0] i,
                                                      input logic [OFFSET_BITS-1:0] o);
    return ADDR_WIDTH'({t, i, o});
  endfunction

  always_ff @(posedge clk) begin
    if (flush) begin
      state        <= ST_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      cache_busy   <= 1'b0;
      is_hit       <= 1'b0;
      addr_main_en <= 1'b0;
      rd_drive     <= 1'b0;
      wb_drive     <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            req_addr   <= addr;
            req_rd     <= is_rd;
            req_wdata  <= data;
            is_hit     <= hit_c;
            cache_busy <= 1'b1;
            rd_drive   <= 1'b0;
            state      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          cnt <= '0;
          if (is_hit) begin
            if (req_rd) begin
              rd_data <= line_data[req_idx_c][req_off_c];
            end else begin
              line_data[req_idx_c][req_off_c] <= req_wdata;
              dirty_q[req_idx_c]              <= 1'b1;
            end
            cache_busy <= 1'b0;
            rd_drive   <= req_rd;
            state      <= ST_IDLE;
          end else if (valid_q[req_idx_c] && dirty_q[req_idx_c]) begin
            addr_main    <= line_addr(tag_arr[req_idx_c], req_idx_c, '0);
            addr_main_en <= 1'b1;
            wb_drive     <= 1'b1;
            wb_byte      <= line_data[req_idx_c][0];
            state        <= ST_WB;
          end else begin
            addr_main    <= line_addr(req_tag_c, req_idx_c, '0);
            addr_main_en <= 1'b1;
            state        <= ST_FILL;
          end
        end
        ST_WB: begin
          if (cnt == LAST_OFF) begin
            wb_drive  <= 1'b0;
            cnt       <= '0;
            addr_main <= line_addr(req_tag_c, req_idx_c, '0);
            state     <= ST_FILL;
          end else begin
            cnt       <= cnt_nxt_c;
            addr_main <= line_addr(tag_arr[req_idx_c], req_idx_c, cnt_nxt_c);
            wb_byte   <= line_data[req_idx_c][cnt_nxt_c];
          end
        end
        ST_FILL: begin
          // One request pulse per byte; the next goes out only after the return.
          addr_main_en <= 1'b0;
          if (data_main_vld == 1'b1) begin
            line_data[req_idx_c][cnt] <= fill_byte_c;
            if (req_rd && cnt == req_off_c) rd_data <= data_main;
            if (cnt == LAST_OFF) begin
              valid_q[req_idx_c] <= 1'b1;
              dirty_q[req_idx_c] <= !req_rd;
              tag_arr[req_idx_c] <= req_tag_c;
              state              <= ST_DONE;
            end else begin
              cnt          <= cnt_nxt_c;
              addr_main    <= line_addr(req_tag_c, req_idx_c, cnt_nxt_c);
              addr_main_en <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          cache_busy <= 1'b0;
          rd_drive   <= req_rd;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data          = rd_drive ? rd_data : {DATA_WIDTH{1'bz}};
  assign data_main     = wb_drive ? wb_byte : {DATA_WIDTH{1'bz}};
  assign data_main_vld = wb_drive ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed bench for direct_mapped_cache backed by main_mem: hits, misses,
// write-back, write-allocate and flush mid-fill.
module tb_direct_mapped_cache;

  logic        clk = 1'b0;
  logic        flush = 1'b1, addr_en = 1'b0, is_rd = 1'b0, data_vld = 1'b0, tb_drv = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  tb_data = '0;
  wire  [7:0]  data, data_main;
  wire         data_main_vld;
  logic        is_hit, cache_busy, addr_main_en;
  logic [15:0] addr_main;

  int checks = 0;
  int errors = 0;

  logic [15:0] la[$];
  logic        lw[$];
  logic [7:0]  ld[$];

  always #5 clk = ~clk;

  assign data = tb_drv ? tb_data : 8'hzz;

  direct_mapped_cache dut (
    .clk(clk), .flush(flush), .addr(addr), .addr_en(addr_en), .is_rd(is_rd),
    .data(data), .data_vld(data_vld), .is_hit(is_hit), .cache_busy(cache_busy),
    .addr_main(addr_main), .addr_main_en(addr_main_en), .data_main(data_main),
    .data_main_vld(data_main_vld)
  );

  main_mem mem (
    .clk(clk), .addr(addr_main), .addr_en(addr_main_en), .data(data_main),
    .data_vld(data_main_vld)
  );

  // Log every memory-side request cycle.
  always @(negedge clk) begin
    if (addr_main_en) begin
      la.push_back(addr_main);
      lw.push_back(data_main_vld === 1'b1);
      ld.push_back(data_main);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_flush(input int n);
    @(negedge clk);
    flush = 1'b1;
    repeat (n) @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_req(input string tag, input logic [15:0] a, input logic rd,
                        input logic [7:0] wd, input int hold,
                        output logic hit, output logic [7:0] rdata, output int busy_n);
    logic seen;
    la.delete(); lw.delete(); ld.delete();
    @(negedge clk);
    addr = a; is_rd = rd; tb_data = wd; tb_drv = !rd; data_vld = !rd; addr_en = 1'b1;
    busy_n = 0; seen = 1'b0; hit = 1'b0; rdata = '0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      tb_drv = 1'b0; data_vld = 1'b0;
      if (c + 1 >= hold) addr_en = 1'b0;
      @(negedge clk);
      if (!seen) begin
        if (cache_busy) busy_n++;
        else begin
          seen = 1'b1; hit = is_hit; rdata = data;
        end
      end
      if (seen && c + 1 >= hold) break;
    end
    addr_en = 1'b0;
    check({tag, "_completed"}, 32'(seen), 32'd1);
    for (int c = 0; c < 300 && cache_busy; c++) @(negedge clk);
  endtask

  task automatic check_fill(input string tag, input int base, input logic [15:0] a0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_fill_addr%0d", tag, i),
            (base + i < la.size()) ? 32'(la[base+i]) : 32'hdead, 32'(a0 + 16'(i)));
      check($sformatf("%s_fill_rd%0d", tag, i),
            (base + i < lw.size()) ? 32'(lw[base+i]) : 32'hdead, 32'd0);
    end
  endtask

  task automatic check_wb(input string tag, input logic [15:0] a0, input logic [31:0] bytes);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_wb_addr%0d", tag, i),
            (i < la.size()) ? 32'(la[i]) : 32'hdead, 32'(a0 + 16'(i)));
      check($sformatf("%s_wb_wr%0d", tag, i), (i < lw.size()) ? 32'(lw[i]) : 32'hdead, 32'd1);
      check($sformatf("%s_wb_data%0d", tag, i),
            (i < ld.size()) ? 32'(ld[i]) : 32'hdead, 32'(bytes[8*(3-i) +: 8]));
    end
  endtask

  initial begin
    logic       hit;
    logic [7:0] rd;
    int         busy;
    logic       saw_fill;

    do_flush(2);
    check("flush_is_hit", 32'(is_hit), 32'd0);
    check("flush_busy", 32'(cache_busy), 32'd0);
    check("flush_addr_main_en", 32'(addr_main_en), 32'd0);

    // Clean read miss: LOOKUP + 4 x 3-cycle fill + DONE.
    do_req("rd0105", 16'h0105, 1'b1, 8'h00, 1, hit, rd, busy);
    check("rd0105_hit", 32'(hit), 32'd0);
    check("rd0105_data", 32'(rd), 32'h05);
    check("rd0105_busy", 32'(busy), 32'd14);
    check("rd0105_nreq", 32'(la.size()), 32'd4);
    check_fill("rd0105", 0, 16'h0104);

    do_flush(1);
    do_req("wrABCD", 16'hABCD, 1'b0, 8'hAA, 1, hit, rd, busy);
    check("wrABCD_hit", 32'(hit), 32'd0);
    check("wrABCD_nreq", 32'(la.size()), 32'd4);
    check_fill("wrABCD", 0, 16'hABCC);

    do_req("rdABCD", 16'hABCD, 1'b1, 8'h00, 3, hit, rd, busy);
    check("rdABCD_hit", 32'(hit), 32'd1);
    check("rdABCD_busy", 32'(busy), 32'd1);
    check("rdABCD_data", 32'(rd), 32'hAA);
    check("rdABCD_nreq", 32'(la.size()), 32'd0);

    do_req("rdABCE", 16'hABCE, 1'b1, 8'h00, 1, hit, rd, busy);
    check("rdABCE_hit", 32'(hit), 32'd1);
    check("rdABCE_busy", 32'(busy), 32'd1);
    check("rdABCE_data", 32'(rd), 32'hCE);

    // Conflict miss on index 3 evicts the dirty 0xABC line first.
    do_req("rd123D", 16'h123D, 1'b1, 8'h00, 1, hit, rd, busy);
    check("rd123D_hit", 32'(hit), 32'd0);
    check("rd123D_data", 32'(rd), 32'h3D);
    check("rd123D_busy", 32'(busy), 32'd18);
    check("rd123D_nreq", 32'(la.size()), 32'd8);
    check_wb("rd123D", 16'hABCC, 32'hCCAACECF);
    check_fill("rd123D", 4, 16'h123C);

    do_req("rdABCD2", 16'hABCD, 1'b1, 8'h00, 1, hit, rd, busy);
    check("rdABCD2_hit", 32'(hit), 32'd0);
    check("rdABCD2_data", 32'(rd), 32'hAA);
    check("rdABCD2_nreq", 32'(la.size()), 32'd4);
    check_fill("rdABCD2", 0, 16'hABCC);

    // Flush while a fill is waiting on memory.
    @(negedge clk);
    addr = 16'h2204; is_rd = 1'b1; addr_en = 1'b1;
    @(posedge clk);
    #1 addr_en = 1'b0;
    saw_fill = 1'b0;
    for (int c = 0; c < 50 && !saw_fill; c++) begin
      @(negedge clk);
      saw_fill = addr_main_en;
    end
    check("midfill_reached", 32'(saw_fill), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("midfill_busy", 32'(cache_busy), 32'd0);
    check("midfill_addr_main_en", 32'(addr_main_en), 32'd0);
    check("midfill_is_hit", 32'(is_hit), 32'd0);
    repeat (6) @(negedge clk);
    do_req("rd2204", 16'h2204, 1'b1, 8'h00, 1, hit, rd, busy);
    check("rd2204_hit", 32'(hit), 32'd0);
    check("rd2204_data", 32'(rd), 32'h04);

    // Write hit marks the line dirty; eviction carries both written bytes.
    do_flush(1);
    do_req("wr0042", 16'h0042, 1'b0, 8'h77, 1, hit, rd, busy);
    check("wr0042_hit", 32'(hit), 32'd0);
    do_req("wr0041", 16'h0041, 1'b0, 8'h66, 1, hit, rd, busy);
    check("wr0041_hit", 32'(hit), 32'd1);
    check("wr0041_busy", 32'(busy), 32'd1);
    check("wr0041_nreq", 32'(la.size()), 32'd0);
    do_req("rd0441", 16'h0441, 1'b1, 8'h00, 1, hit, rd, busy);
    check("rd0441_hit", 32'(hit), 32'd0);
    check("rd0441_data", 32'(rd), 32'h41);
    check_wb("rd0441", 16'h0040, 32'h40667743);
    check_fill("rd0441", 4, 16'h0440);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
